// File: rtl/stage_ctrl_pkg.sv
// Shared definitions for the pipeline stage controller: FSM encodings,
// start-up length, the hard-wired zero register and a register-match helper.
package stage_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_DBG_HALT = 2'd3
  } state_e;

  // Number of cycles spent in INIT after reset is released.
  localparam int unsigned INIT_LEN   = 2;
  localparam int unsigned INIT_CNT_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

  // Register 0 always reads as zero, so it can never carry a dependency.
  localparam logic [4:0] GPR_ZERO = 5'd0;

  // One bit per pipeline stage, IF first.
  typedef struct packed {
    logic if_s;
    logic id_s;
    logic exe_s;
    logic mem_s;
    logic wb_s;
  } stage_vec_t;

  // True when a non-zero source register is about to be written by EXE or MEM.
  function automatic logic reg_pending_write(
    input logic [4:0] src,
    input logic       wen_exe,
    input logic [4:0] dst_exe,
    input logic       wen_mem,
    input logic [4:0] dst_mem
  );
    return (src != GPR_ZERO) &&
           ((wen_exe && (dst_exe == src)) || (wen_mem && (dst_mem == src)));
  endfunction

endpackage

// File: rtl/stage_ctrl_hazard_detect.sv
// Read-after-write hazard detector for the instruction in ID. WB is not
// checked because the register file writes before it is read.
module stage_ctrl_hazard_detect
  import stage_ctrl_pkg::*;
(
  input  logic       id_valid_i,
  input  logic [4:0] addr_rs_i,
  input  logic [4:0] addr_rt_i,
  input  logic       rs_used_i,
  input  logic       rt_used_i,
  input  logic [4:0] regw_addr_exe_i,
  input  logic [4:0] regw_addr_mem_i,
  input  logic       wb_wen_exe_i,
  input  logic       wb_wen_mem_i,
  output logic       hazard_o
);

  logic rs_hit;
  logic rt_hit;

  // A used source that matches a pending EXE/MEM write forces a stall.
  always_comb begin
    rs_hit   = rs_used_i && reg_pending_write(addr_rs_i, wb_wen_exe_i, regw_addr_exe_i,
                                              wb_wen_mem_i, regw_addr_mem_i);
    rt_hit   = rt_used_i && reg_pending_write(addr_rt_i, wb_wen_exe_i, regw_addr_exe_i,
                                              wb_wen_mem_i, regw_addr_mem_i);
    hazard_o = id_valid_i && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/stage_ctrl.sv
// Five-stage pipeline sequencer: start-up flush, branch squash, load-use
// stall, memory-wait freeze and single-step debug, plus cycle/stall counters.
//
//   state     | meaning
//   INIT      | post-reset flush, all stages held in reset for INIT_LEN cycles
//   RUN       | pipeline advances, modified by branch/hazard/memory rules
//   MEM_WAIT  | full freeze until memory reports completion
//   DBG_HALT  | full freeze, released by debug_en=0 or a single step
module stage_ctrl
  import stage_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        debug_en,
  input  logic        debug_step,
  input  logic        id_valid,
  input  logic [4:0]  addr_rs,
  input  logic [4:0]  addr_rt,
  input  logic        rs_used,
  input  logic        rt_used,
  input  logic        is_branch_exe,
  input  logic        is_branch_mem,
  input  logic [4:0]  regw_addr_exe,
  input  logic [4:0]  regw_addr_mem,
  input  logic        wb_wen_exe,
  input  logic        wb_wen_mem,
  input  logic        mem_access,
  input  logic        mem_ready,
  output logic        if_rst,
  output logic        id_rst,
  output logic        exe_rst,
  output logic        mem_rst,
  output logic        wb_rst,
  output logic        if_en,
  output logic        id_en,
  output logic        exe_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic [1:0]  state,
  output logic [15:0] cycle_cnt,
  output logic [15:0] stall_cnt
);

  localparam logic [INIT_CNT_W-1:0] INIT_RELOAD = INIT_CNT_W'(INIT_LEN - 1);

  state_e                state_q, state_d;
  logic [INIT_CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic                  step_pend_q, step_pend_d;
  logic                  step_prev_q;
  logic [15:0]           cycle_cnt_q;
  logic [15:0]           stall_cnt_q;
  logic                  hazard;
  logic                  mem_stall;
  stage_vec_t            rst_vec;
  stage_vec_t            en_vec;

  stage_ctrl_hazard_detect u_hazard_detect (
    .id_valid_i      (id_valid),
    .addr_rs_i       (addr_rs),
    .addr_rt_i       (addr_rt),
    .rs_used_i       (rs_used),
    .rt_used_i       (rt_used),
    .regw_addr_exe_i (regw_addr_exe),
    .regw_addr_mem_i (regw_addr_mem),
    .wb_wen_exe_i    (wb_wen_exe),
    .wb_wen_mem_i    (wb_wen_mem),
    .hazard_o        (hazard)
  );

  assign mem_stall = mem_access && !mem_ready;

  // Per-stage flush/advance; a memory stall outranks branch and hazard handling.
  always_comb begin
    rst_vec = '0;
    en_vec  = '0;
    if (rst || (state_q == ST_INIT)) begin
      rst_vec = '1;
    end else if ((state_q == ST_RUN) && !mem_stall) begin
      en_vec = '1;
      if (is_branch_mem) begin
        rst_vec.id_s = 1'b1;
      end else if (is_branch_exe) begin
        en_vec.if_s   = 1'b0;
        rst_vec.id_s  = 1'b1;
        rst_vec.exe_s = 1'b1;
      end else if (hazard) begin
        en_vec.if_s   = 1'b0;
        en_vec.id_s   = 1'b0;
        rst_vec.exe_s = 1'b1;
      end
    end
  end

  // Next state, INIT down-counter and step-request bookkeeping.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    step_pend_d = step_pend_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == '0) state_d = debug_en ? ST_DBG_HALT : ST_RUN;
        else                  init_cnt_d = init_cnt_q - 1'b1;
      end
      ST_RUN: begin
        if (mem_stall)                      state_d = ST_MEM_WAIT;
        else if (debug_en && !step_pend_q)  state_d = ST_DBG_HALT;
      end
      ST_MEM_WAIT: begin
        if (mem_ready) state_d = ST_RUN;
      end
      ST_DBG_HALT: begin
        if (!debug_en) begin
          state_d = ST_RUN;
        end else if (step_pend_q) begin
          state_d     = ST_RUN;
          step_pend_d = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
    // A new step edge wins over the clear so a quick re-press is not lost.
    if (debug_step && !step_prev_q) step_pend_d = 1'b1;
  end

  // State, step history and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= INIT_RELOAD;
      step_pend_q <= 1'b0;
      step_prev_q <= 1'b0;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      step_pend_q <= step_pend_d;
      step_prev_q <= debug_step;
      if (state_q != ST_INIT) cycle_cnt_q <= cycle_cnt_q + 16'd1;
      if (((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !en_vec.if_s)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = rst_vec;
  assign {if_en, id_en, exe_en, mem_en, wb_en}      = en_vec;
  assign state     = state_q;
  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stage_ctrl.sv
// Scoreboard bench for stage_ctrl: a cycle-level reference model pushes the
// expected outputs for every driven cycle, a monitor pops and compares them,
// and a few directed scenarios add explicit constant checks.
module tb_stage_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, debug_en, debug_step, id_valid;
  logic [4:0]  addr_rs, addr_rt, regw_addr_exe, regw_addr_mem;
  logic        rs_used, rt_used, is_branch_exe, is_branch_mem;
  logic        wb_wen_exe, wb_wen_mem, mem_access, mem_ready;
  logic        if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic        if_en, id_en, exe_en, mem_en, wb_en;
  logic [1:0]  state;
  logic [15:0] cycle_cnt, stall_cnt;

  stage_ctrl dut (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .id_valid(id_valid), .addr_rs(addr_rs), .addr_rt(addr_rt),
    .rs_used(rs_used), .rt_used(rt_used),
    .is_branch_exe(is_branch_exe), .is_branch_mem(is_branch_mem),
    .regw_addr_exe(regw_addr_exe), .regw_addr_mem(regw_addr_mem),
    .wb_wen_exe(wb_wen_exe), .wb_wen_mem(wb_wen_mem),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
    .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
    .state(state), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [4:0]  rsts;
    logic [4:0]  ens;
    logic [1:0]  st;
    logic [15:0] cc;
    logic [15:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: modes 0=INIT 1=RUN 2=MEM_WAIT 3=DBG_HALT
  int          m_mode = 0;
  int          m_init_left = 2;
  bit          m_pend = 0, m_prev = 0, m_known = 0;
  logic [15:0] m_cc = 0, m_sc = 0;

  function automatic bit pending_write(input logic [4:0] a);
    return (a != 5'd0) && ((wb_wen_exe && regw_addr_exe == a) || (wb_wen_mem && regw_addr_mem == a));
  endfunction

  task automatic model_cycle();
    logic [4:0] r, en;
    bit haz, rise;
    haz = id_valid && ((rs_used && pending_write(addr_rs)) || (rt_used && pending_write(addr_rt)));
    r = 5'b00000; en = 5'b00000;
    if (rst || m_mode == 0)                  r  = 5'b11111;
    else if (m_mode == 2 || m_mode == 3)     en = 5'b00000;
    else if (mem_access && !mem_ready)       en = 5'b00000;
    else if (is_branch_mem) begin r = 5'b01000; en = 5'b11111; end
    else if (is_branch_exe) begin r = 5'b01100; en = 5'b01111; end
    else if (haz)           begin r = 5'b00100; en = 5'b00111; end
    else                          en = 5'b11111;
    if (m_known) exp_q.push_back('{rsts: r, ens: en, st: 2'(m_mode), cc: m_cc, sc: m_sc});
    if (rst) begin
      m_mode = 0; m_init_left = 2; m_cc = 0; m_sc = 0; m_pend = 0; m_prev = 0; m_known = 1;
    end else begin
      rise   = debug_step && !m_prev;
      m_prev = debug_step;
      if (m_mode != 0) m_cc = m_cc + 16'd1;
      if ((m_mode == 1 || m_mode == 2) && !en[4]) m_sc = m_sc + 16'd1;
      case (m_mode)
        0: begin m_init_left--; if (m_init_left == 0) m_mode = debug_en ? 3 : 1; end
        1: if (mem_access && !mem_ready) m_mode = 2; else if (debug_en && !m_pend) m_mode = 3;
        2: if (mem_ready) m_mode = 1;
        default: if (!debug_en) m_mode = 1; else if (m_pend) begin m_mode = 1; m_pend = 0; end
      endcase
      if (rise) m_pend = 1;
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the next expectation.
  initial begin
    exp_t e, a;
    int cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{rsts: {if_rst, id_rst, exe_rst, mem_rst, wb_rst},
              ens:  {if_en, id_en, exe_en, mem_en, wb_en},
              st: state, cc: cycle_cnt, sc: stall_cnt};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL sb cyc=%0d act rst=%b en=%b st=%0d cc=%0d sc=%0d exp rst=%b en=%b st=%0d cc=%0d sc=%0d",
                   cyc, a.rsts, a.ens, a.st, a.cc, a.sc, e.rsts, e.ens, e.st, e.cc, e.sc);
        end
      end
    end
  end

  task automatic dchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    debug_step = 0; id_valid = 0; addr_rs = 0; addr_rt = 0; rs_used = 0; rt_used = 0;
    is_branch_exe = 0; is_branch_mem = 0; regw_addr_exe = 0; regw_addr_mem = 0;
    wb_wen_exe = 0; wb_wen_mem = 0; mem_access = 0; mem_ready = 1;
  endtask

  task automatic eval(); model_cycle(); @(negedge clk); endtask
  task automatic adv();  @(posedge clk); #1; endtask
  task automatic tick(); eval(); adv(); endtask

  initial begin
    logic [15:0] base_sc;
    int run_cnt;
    rst = 1; debug_en = 0; idle();
    adv();

    // Reset then run
    repeat (3) tick();
    rst = 0;
    eval(); dchk("init1_rst", {if_rst, id_rst, exe_rst, mem_rst, wb_rst, if_en, id_en, exe_en, mem_en, wb_en}, 10'h3e0); adv();
    eval(); dchk("init2_rst", {if_rst, id_rst, exe_rst, mem_rst, wb_rst, if_en, id_en, exe_en, mem_en, wb_en}, 10'h3e0); adv();
    eval(); dchk("run_state", state, 1);
    dchk("run_en", {if_rst, id_rst, exe_rst, mem_rst, wb_rst, if_en, id_en, exe_en, mem_en, wb_en}, 10'h01f); adv();
    eval(); dchk("cycle_cnt1", cycle_cnt, 1); adv();

    // RAW hazard, then the same with register 0
    id_valid = 1; rs_used = 1; addr_rs = 5; wb_wen_exe = 1; regw_addr_exe = 5;
    eval(); dchk("raw_stall", {if_en, id_en, exe_rst}, 3'b001); adv();
    addr_rs = 0; regw_addr_exe = 0;
    eval(); dchk("raw_r0", {if_en, id_en, exe_rst}, 3'b110); adv();
    idle(); tick();

    // Branch in EXE then MEM
    base_sc = m_sc;
    is_branch_exe = 1;
    eval(); dchk("br_exe", {if_en, id_rst, exe_rst}, 3'b011); adv();
    is_branch_exe = 0; is_branch_mem = 1;
    eval(); dchk("br_mem", {if_en, id_rst, exe_rst}, 3'b110);
    dchk("br_stall_cnt", stall_cnt, 32'(base_sc + 16'd1)); adv();
    idle(); tick();

    // Memory wait: ready low 3 cycles then high
    mem_access = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1;
      eval();
      dchk("mw_en", {if_en, id_en, exe_en, mem_en, wb_en}, 5'b00000);
      dchk("mw_state", state, (i == 0) ? 1 : 2);
      adv();
    end
    idle();
    eval(); dchk("mw_back", {state, if_en, wb_en}, 4'b0111); adv();

    // Memory wait beats a branch in MEM
    mem_access = 1; mem_ready = 0; is_branch_mem = 1;
    eval(); dchk("mw_br", {id_rst, if_en, id_en}, 3'b000); adv();
    is_branch_mem = 0; mem_ready = 1; tick();
    idle(); tick();

    // Single step with debug_step held for 5 cycles
    rst = 1; debug_en = 1; tick();
    rst = 0; tick(); tick();
    eval(); dchk("dbg_halt", state, 3); adv();
    run_cnt = 0;
    debug_step = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) debug_step = 0;
      eval(); if (state == 2'd1) run_cnt++; adv();
    end
    dchk("step_once", run_cnt, 1);
    tick();
    debug_step = 1; tick(); tick();
    rst = 1;
    eval(); dchk("step_run", state, 1); adv();
    rst = 0;
    eval(); dchk("step_rst", {state, if_rst, wb_rst, if_en}, 5'b00110); adv();
    debug_en = 0; debug_step = 0; repeat (3) tick();

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst           = ($urandom_range(199) == 0);
      debug_en      = (i >= 2000) ? ($urandom_range(9) < 3) : 1'b0;
      debug_step    = ($urandom_range(3) == 0);
      id_valid      = ($urandom_range(3) != 0);
      addr_rs       = 5'($urandom_range(3));
      addr_rt       = 5'($urandom_range(3));
      rs_used       = $urandom_range(1);
      rt_used       = $urandom_range(1);
      is_branch_exe = ($urandom_range(9) == 0);
      is_branch_mem = ($urandom_range(9) == 0);
      regw_addr_exe = 5'($urandom_range(3));
      regw_addr_mem = 5'($urandom_range(3));
      wb_wen_exe    = $urandom_range(1);
      wb_wen_mem    = $urandom_range(1);
      mem_access    = ($urandom_range(9) < 3);
      mem_ready     = ($urandom_range(9) < 6);
      tick();
    end
    rst = 0; idle();

    repeat (3) @(negedge clk);
    dchk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_ctrl.md
STAGE_CTRL -- requirements
Module: stage_ctrl

Interface
REQ-001 The block SHALL have these ports, clock and reset first, with names, directions and widths exactly as listed:
- clk  in  1  main clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- debug_en  in  1  single-step mode enable.
- debug_step  in  1  step request (level; rising edge used).
- id_valid  in  1  ID stage holds a real instruction.
- addr_rs, addr_rt  in  5 each  source registers of the instruction in ID.
- rs_used, rt_used  in  1 each  the instruction in ID reads rs / rt.
- is_branch_exe, is_branch_mem  in  1 each  jump/branch in EXE / MEM.
- regw_addr_exe, regw_addr_mem  in  5 each  destination register in EXE / MEM.
- wb_wen_exe, wb_wen_mem  in  1 each  register write enable in EXE / MEM.
- mem_access  in  1  MEM stage is issuing a load or store.
- mem_ready  in  1  memory completes the current access this cycle.
- if_rst, id_rst, exe_rst, mem_rst, wb_rst  out  1 each  per-stage flush.
- if_en, id_en, exe_en, mem_en, wb_en  out  1 each  per-stage advance.
- state  out  2  current FSM state.
- cycle_cnt, stall_cnt  out  16 each  performance counters.

Function
REQ-002 The FSM SHALL have 4 states: INIT=0, RUN=1, MEM_WAIT=2, DBG_HALT=3.
REQ-003 INIT SHALL last exactly 2 cycles and SHALL drive all *_rst=1 and all *_en=0; it SHALL then go to DBG_HALT if debug_en=1, otherwise to RUN.
REQ-004 In MEM_WAIT and DBG_HALT, all *_rst SHALL be 0 and all *_en SHALL be 0 (full freeze).
REQ-005 In RUN, the default output SHALL be all *_en=1 and all *_rst=0, modified by the first rule that matches in REQ-006..REQ-008.
REQ-006 If is_branch_mem=1, the block SHALL drive id_rst=1; IF loads the target.
REQ-007 Else if is_branch_exe=1, the block SHALL drive if_en=0, id_rst=1 and exe_rst=1.
  - The total branch penalty is 3 bubbles.
  - There are no delay slots.
REQ-008 Else if a hazard exists (REQ-009), the block SHALL drive if_en=0, id_en=0 and exe_rst=1, inserting 1 bubble and holding IF/ID.
REQ-009 A hazard SHALL exist when all of the following hold:
  - id_valid=1;
  - (rs_used and addr_rs != 0 and addr_rs matches a writing stage) or (rt_used and addr_rt != 0 and addr_rt matches a writing stage);
  - a writing stage is EXE with wb_wen_exe=1 and regw_addr_exe equal to the address, or MEM with wb_wen_mem=1 and regw_addr_mem equal to the address.
REQ-010 The hazard check SHALL NOT consider the WB stage; the regfile is write-before-read.
REQ-011 The block SHALL NOT forward data.
REQ-012 In RUN, if mem_access=1 and mem_ready=0, the outputs SHALL be a full freeze this cycle and next state SHALL be MEM_WAIT; this has priority over REQ-006..REQ-008.
REQ-013 MEM_WAIT SHALL return to RUN in the cycle after mem_ready=1.
  - In the mem_ready=1 cycle the outputs SHALL still freeze, and mem_din is captured on the next RUN cycle.
  - debug_en SHALL be ignored while in MEM_WAIT.
REQ-014 In RUN, if debug_en=1 and no step is pending, next state SHALL be DBG_HALT; the current cycle advances normally.
REQ-015 step_pend SHALL be set on a registered rising edge of debug_step (debug_step=1 and its previous sampled value 0); a held level SHALL count once.
REQ-016 In DBG_HALT with step_pend=1, the block SHALL enter RUN for exactly 1 cycle, clear step_pend, then return to DBG_HALT.
  - This does not apply if MEM_WAIT is triggered.
REQ-017 In DBG_HALT with debug_en=0, the block SHALL go to RUN.
REQ-018 cycle_cnt SHALL increment every cycle outside INIT.
REQ-019 stall_cnt SHALL increment in every cycle where if_en=0 outside INIT and DBG_HALT.
REQ-020 Both counters SHALL wrap from 16'hFFFF to 0.
REQ-021 All *_rst/*_en outputs SHALL be combinational from state and inputs; state, counters and step logic SHALL be registered.

Reset
REQ-022 While rst=1, the block SHALL:
  - set state to INIT with the INIT counter reloaded;
  - drive all *_rst=1 and all *_en=0;
  - set cycle_cnt=0, stall_cnt=0, step_pend=0 and the debug_step history to 0.
REQ-023 Reset asserted mid-stall, mid-wait or mid-step SHALL abandon the operation and give the REQ-022 values on the next edge.

Structure
REQ-024 The state encodings, INIT length (2) and GPR_ZERO (5'd0) SHALL live in the shared mips_define header alongside PC_* / WB_* constants.
REQ-025 Hazard detection SHALL be one sub-module, hazard_detect (purely combinational, 1-bit output).

Verification
REQ-026 The bench SHALL cover at least these directed scenarios:
- Reset then run: rst high 3 cycles then low -> all rst=1 for 2 more cycles, then state=RUN with all en=1; cycle_cnt=1 one cycle later.
- RAW hazard: id_valid=1, rs_used=1, addr_rs=5, wb_wen_exe=1, regw_addr_exe=5 -> if_en=0, id_en=0, exe_rst=1. Same with addr_rs=0 -> no stall.
- Branch: is_branch_exe=1 for 1 cycle then is_branch_mem=1 -> cycle 1: if_en=0, id_rst=1, exe_rst=1; cycle 2: if_en=1, id_rst=1; stall_cnt +1.
- Memory wait: mem_access=1, mem_ready=0 for 3 cycles, then 1 -> all en=0 for 4 cycles, state=2 for 3 cycles, then RUN.
- Memory wait plus branch: is_branch_mem=1 while mem_access=1 and mem_ready=0 -> freeze wins; id_rst=0.
- Single step: debug_en=1, debug_step high for 5 cycles -> exactly one RUN cycle, then DBG_HALT; rst during that RUN cycle -> INIT.
